// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared encodings and state type for the load/store unit
package lsu_pkg;

    localparam int MEM_WORDS_DEFAULT = 256;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2,
        ST_RESP  = 2'd3
    } lsu_state_e;

endpackage

// File: rtl/lsu_lane_merge.sv
// rtl/lsu_lane_merge.sv - little-endian lane insert for stores and lane extract/extend for loads
module lsu_lane_merge
    import lsu_pkg::*;
(
    input  logic [31:0] word_in,
    input  logic [1:0]  lane,
    input  logic [1:0]  size,
    input  logic        sign_ext,
    input  logic [31:0] store_data,
    output logic [31:0] merged_word,
    output logic [31:0] load_value
);

    logic [4:0]  byte_shamt;
    logic [4:0]  half_shamt;
    logic [31:0] shifted;

    always_comb begin
        byte_shamt  = {lane, 3'b000};
        half_shamt  = {lane[1], 4'b0000};
        merged_word = store_data;
        load_value  = word_in;
        shifted     = word_in;
        case (size)
            SIZE_BYTE: begin
                merged_word = (word_in & ~(32'h0000_00FF << byte_shamt))
                            | ({24'h0, store_data[7:0]} << byte_shamt);
                shifted     = word_in >> byte_shamt;
                load_value  = {{24{sign_ext & shifted[7]}}, shifted[7:0]};
            end
            SIZE_HALF: begin
                merged_word = (word_in & ~(32'h0000_FFFF << half_shamt))
                            | ({16'h0, store_data[15:0]} << half_shamt);
                shifted     = word_in >> half_shamt;
                load_value  = {{16{sign_ext & shifted[15]}}, shifted[15:0]};
            end
            default: begin
                merged_word = store_data;
                load_value  = word_in;
            end
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - multicycle byte/half/word load-store sequencer with read-modify-write
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int MEM_WORDS = MEM_WORDS_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        is_store,
    input  logic [1:0]  size,
    input  logic        sign_ext,
    input  logic [31:0] addr,
    input  logic [31:0] store_data,
    output logic        busy,
    output logic        done,
    output logic        fault,
    output logic [31:0] load_data,
    output logic [15:0] mem_addr,
    output logic        mem_write_en,
    output logic [31:0] mem_write_data,
    input  logic [31:0] mem_read_data
);

    lsu_state_e  state_q, state_d;
    logic        is_store_q, is_store_d;
    logic [1:0]  size_q, size_d;
    logic        sign_ext_q, sign_ext_d;
    logic [1:0]  lane_q, lane_d;
    logic [31:0] store_data_q, store_data_d;
    logic        fault_q, fault_d;
    logic [31:0] load_data_q, load_data_d;
    logic [15:0] mem_addr_q, mem_addr_d;
    logic        mem_write_en_q, mem_write_en_d;
    logic [31:0] mem_write_data_q, mem_write_data_d;

    logic        req_fault;
    logic [31:0] merged_word;
    logic [31:0] load_value;

    // Memory read data is combinational on the registered address, so the merge
    // works straight off it during READ and the result is registered on exit.
    lsu_lane_merge u_lane_merge (
        .word_in     (mem_read_data),
        .lane        (lane_q),
        .size        (size_q),
        .sign_ext    (sign_ext_q),
        .store_data  (store_data_q),
        .merged_word (merged_word),
        .load_value  (load_value)
    );

    always_comb begin
        req_fault = (size == 2'd3)
                 || (size == SIZE_HALF && addr[0])
                 || (size == SIZE_WORD && addr[1:0] != 2'b00)
                 || ({2'b00, addr[31:2]} >= 32'(MEM_WORDS));
    end

    always_comb begin
        state_d          = state_q;
        is_store_d       = is_store_q;
        size_d           = size_q;
        sign_ext_d       = sign_ext_q;
        lane_d           = lane_q;
        store_data_d     = store_data_q;
        fault_d          = fault_q;
        load_data_d      = load_data_q;
        mem_addr_d       = mem_addr_q;
        mem_write_en_d   = 1'b0;
        mem_write_data_d = mem_write_data_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    is_store_d   = is_store;
                    size_d       = size;
                    sign_ext_d   = sign_ext;
                    lane_d       = addr[1:0];
                    store_data_d = store_data;
                    mem_addr_d   = addr[17:2];
                    fault_d      = req_fault;
                    if (req_fault) begin
                        state_d = ST_RESP;
                    end else if (is_store && size == SIZE_WORD) begin
                        mem_write_data_d = store_data;
                        mem_write_en_d   = 1'b1;
                        state_d          = ST_WRITE;
                    end else begin
                        state_d = ST_READ;
                    end
                end
            end
            ST_READ: begin
                if (is_store_q) begin
                    mem_write_data_d = merged_word;
                    mem_write_en_d   = 1'b1;
                    state_d          = ST_WRITE;
                end else begin
                    load_data_d = load_value;
                    state_d     = ST_RESP;
                end
            end
            ST_WRITE: begin
                state_d = ST_RESP;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q          <= ST_IDLE;
            is_store_q       <= 1'b0;
            size_q           <= SIZE_BYTE;
            sign_ext_q       <= 1'b0;
            lane_q           <= 2'b00;
            store_data_q     <= 32'h0;
            fault_q          <= 1'b0;
            load_data_q      <= 32'h0;
            mem_addr_q       <= 16'h0;
            mem_write_en_q   <= 1'b0;
            mem_write_data_q <= 32'h0;
        end else begin
            state_q          <= state_d;
            is_store_q       <= is_store_d;
            size_q           <= size_d;
            sign_ext_q       <= sign_ext_d;
            lane_q           <= lane_d;
            store_data_q     <= store_data_d;
            fault_q          <= fault_d;
            load_data_q      <= load_data_d;
            mem_addr_q       <= mem_addr_d;
            mem_write_en_q   <= mem_write_en_d;
            mem_write_data_q <= mem_write_data_d;
        end
    end

    assign busy           = (state_q != ST_IDLE);
    assign done           = (state_q == ST_RESP);
    assign fault          = done && fault_q;
    assign load_data      = load_data_q;
    assign mem_addr       = mem_addr_q;
    assign mem_write_en   = mem_write_en_q;
    assign mem_write_data = mem_write_data_q;

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - directed vector bench for load_store_unit with a word memory model
module tb_load_store_unit;

    logic        clk;
    logic        rst;
    logic        start;
    logic        is_store;
    logic [1:0]  size;
    logic        sign_ext;
    logic [31:0] addr;
    logic [31:0] store_data;
    logic        busy;
    logic        done;
    logic        fault;
    logic [31:0] load_data;
    logic [15:0] mem_addr;
    logic        mem_write_en;
    logic [31:0] mem_write_data;
    logic [31:0] mem_read_data;

    logic [31:0] ram [0:255];
    int          n_checks;
    int          n_fail;
    int          total_writes;

    load_store_unit #(.MEM_WORDS(256)) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .is_store       (is_store),
        .size           (size),
        .sign_ext       (sign_ext),
        .addr           (addr),
        .store_data     (store_data),
        .busy           (busy),
        .done           (done),
        .fault          (fault),
        .load_data      (load_data),
        .mem_addr       (mem_addr),
        .mem_write_en   (mem_write_en),
        .mem_write_data (mem_write_data),
        .mem_read_data  (mem_read_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mem_read_data = ram[mem_addr[7:0]];

    always @(posedge clk) begin
        if (mem_write_en) begin
            ram[mem_addr[7:0]] <= mem_write_data;
            total_writes       <= total_writes + 1;
        end
    end

    typedef struct {
        logic        st;
        logic [1:0]  sz;
        logic        se;
        logic [31:0] a;
        logic [31:0] sd;
        logic        exp_fault;
        int          exp_lat;
        int          exp_wcyc;
        logic [31:0] exp_wdata;
        logic [31:0] exp_load;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int lat;
        int wcyc;
        int nwr;
        logic [31:0] wdat;
        logic flt;
        lat  = 0;
        wcyc = 0;
        nwr  = 0;
        wdat = 32'h0;
        flt  = 1'b0;
        @(negedge clk);
        start      = 1'b1;
        is_store   = v.st;
        size       = v.sz;
        sign_ext   = v.se;
        addr       = v.a;
        store_data = v.sd;
        @(posedge clk);
        #1 start = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (mem_write_en) begin
                nwr++;
                wcyc = c;
                wdat = mem_write_data;
            end
            if (done) begin
                lat = c;
                flt = fault;
                break;
            end
        end
        check($sformatf("v%0d latency", idx), 32'(lat), 32'(v.exp_lat));
        check($sformatf("v%0d fault", idx), {31'h0, flt}, {31'h0, v.exp_fault});
        check($sformatf("v%0d write_count", idx), 32'(nwr), (v.exp_wcyc != 0) ? 32'd1 : 32'd0);
        if (v.exp_wcyc != 0) begin
            check($sformatf("v%0d write_cycle", idx), 32'(wcyc), 32'(v.exp_wcyc));
            check($sformatf("v%0d write_data", idx), wdat, v.exp_wdata);
        end
        check($sformatf("v%0d load_data", idx), load_data, v.exp_load);
    endtask

    vec_t vecs [13];

    initial begin
        int w0;
        int dones;
        n_checks     = 0;
        n_fail       = 0;
        total_writes = 0;
        for (int i = 0; i < 256; i++) ram[i] = 32'(i);

        //            st    sz    se    addr        sdata         flt  lat wcyc wdata         load
        vecs[0]  = '{1'b0, 2'd2, 1'b0, 32'h14,  32'h0,        1'b0, 2, 0, 32'h0,        32'h0000_0005};
        vecs[1]  = '{1'b1, 2'd0, 1'b0, 32'h0D,  32'hFFFF_FFAB, 1'b0, 3, 2, 32'h0000_AB03, 32'h0000_0005};
        vecs[2]  = '{1'b0, 2'd0, 1'b1, 32'h0D,  32'h0,        1'b0, 2, 0, 32'h0,        32'hFFFF_FFAB};
        vecs[3]  = '{1'b0, 2'd0, 1'b0, 32'h0D,  32'h0,        1'b0, 2, 0, 32'h0,        32'h0000_00AB};
        vecs[4]  = '{1'b1, 2'd1, 1'b0, 32'h03,  32'h1234,     1'b1, 1, 0, 32'h0,        32'h0000_00AB};
        vecs[5]  = '{1'b0, 2'd2, 1'b0, 32'h400, 32'h0,        1'b1, 1, 0, 32'h0,        32'h0000_00AB};
        vecs[6]  = '{1'b0, 2'd3, 1'b0, 32'h10,  32'h0,        1'b1, 1, 0, 32'h0,        32'h0000_00AB};
        vecs[7]  = '{1'b1, 2'd1, 1'b0, 32'h12,  32'h5555_8765, 1'b0, 3, 2, 32'h8765_0004, 32'h0000_00AB};
        vecs[8]  = '{1'b0, 2'd1, 1'b1, 32'h12,  32'h0,        1'b0, 2, 0, 32'h0,        32'hFFFF_8765};
        vecs[9]  = '{1'b0, 2'd1, 1'b0, 32'h12,  32'h0,        1'b0, 2, 0, 32'h0,        32'h0000_8765};
        vecs[10] = '{1'b1, 2'd0, 1'b0, 32'h12,  32'h0000_005A, 1'b0, 3, 2, 32'h875A_0004, 32'h0000_8765};
        vecs[11] = '{1'b0, 2'd0, 1'b1, 32'h13,  32'h0,        1'b0, 2, 0, 32'h0,        32'hFFFF_FF87};
        vecs[12] = '{1'b0, 2'd2, 1'b1, 32'h3FC, 32'h0,        1'b0, 2, 0, 32'h0,        32'h0000_00FF};

        rst        = 1'b1;
        start      = 1'b0;
        is_store   = 1'b0;
        size       = 2'd0;
        sign_ext   = 1'b0;
        addr       = 32'h0;
        store_data = 32'h0;
        repeat (2) @(negedge clk);
        check("reset busy", {31'h0, busy}, 32'h0);
        check("reset done", {31'h0, done}, 32'h0);
        check("reset fault", {31'h0, fault}, 32'h0);
        check("reset mem_write_en", {31'h0, mem_write_en}, 32'h0);
        check("reset load_data", load_data, 32'h0);
        check("reset mem_addr", {16'h0, mem_addr}, 32'h0);
        check("reset mem_write_data", mem_write_data, 32'h0);
        rst = 1'b0;

        for (int i = 0; i < 13; i++) run_vec(i, vecs[i]);
        check("ram word 3 after byte store", ram[3], 32'h0000_AB03);
        check("ram word 0 untouched by faults", ram[0], 32'h0);

        // Word store with a second start pulsed while busy
        w0 = total_writes;
        @(negedge clk);
        start      = 1'b1;
        is_store   = 1'b1;
        size       = 2'd2;
        addr       = 32'h20;
        store_data = 32'hDEAD_BEEF;
        @(posedge clk);
        #1;
        is_store = 1'b0;
        addr     = 32'h14;
        @(negedge clk);
        check("wstore cycle1 write_en", {31'h0, mem_write_en}, 32'h1);
        check("wstore cycle1 mem_addr", {16'h0, mem_addr}, 32'h8);
        check("wstore cycle1 write_data", mem_write_data, 32'hDEAD_BEEF);
        @(negedge clk);
        check("wstore cycle2 done", {31'h0, done}, 32'h1);
        start = 1'b0;
        dones = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (done) dones++;
        end
        check("wstore extra done count", 32'(dones), 32'h0);
        check("wstore write count", 32'(total_writes - w0), 32'h1);
        check("wstore ram word 8", ram[8], 32'hDEAD_BEEF);

        // Reset during the WRITE cycle of a sub-word store
        w0 = total_writes;
        @(negedge clk);
        start      = 1'b1;
        is_store   = 1'b1;
        size       = 2'd0;
        addr       = 32'h08;
        store_data = 32'h0000_0011;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rmw pre-reset write_en", {31'h0, mem_write_en}, 32'h1);
        rst = 1'b1;
        #1;
        check("mid reset write_en", {31'h0, mem_write_en}, 32'h0);
        check("mid reset busy", {31'h0, busy}, 32'h0);
        check("mid reset done", {31'h0, done}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        check("mid reset no write", 32'(total_writes - w0), 32'h0);
        check("mid reset ram word 2", ram[2], 32'h2);
        run_vec(13, '{1'b1, 2'd0, 1'b0, 32'h09, 32'h0000_0077, 1'b0, 3, 2, 32'h0000_7702, 32'h0});
        run_vec(14, '{1'b0, 2'd2, 1'b0, 32'h20, 32'h0,        1'b0, 2, 0, 32'h0,        32'hDEAD_BEEF});

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
